// File: rtl/banked_ram_2r1w.sv
// Banked RAM, one write port and two registered read ports, hardware clear sweep after reset.
// Define BANKED_RAM_BYPASS_EN to forward same-edge write data to a colliding read (write-first).
module banked_ram_2r1w #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned BANK_SEL_W  = 3,
  parameter int unsigned BANK_ADDR_W = 10
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              wr,
  input  logic [BANK_SEL_W+BANK_ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]                 d_in,
  input  logic                              rd_en_a,
  input  logic [BANK_SEL_W+BANK_ADDR_W-1:0] rd_addr_a,
  input  logic                              rd_en_b,
  input  logic [BANK_SEL_W+BANK_ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0]                 d_out_a,
  output logic                              valid_a,
  output logic [DATA_W-1:0]                 d_out_b,
  output logic                              valid_b,
  output logic                              init_busy
);

  localparam int unsigned ADDR_W = BANK_SEL_W + BANK_ADDR_W;
  localparam int unsigned NBANK  = 2 ** BANK_SEL_W;
  localparam int unsigned DEPTH  = 2 ** BANK_ADDR_W;

  typedef enum logic {INIT, READY} state_t;

  state_t                 state;
  logic [BANK_ADDR_W-1:0] clr_ptr;
  logic [DATA_W-1:0]      mem [NBANK][DEPTH];

  logic [BANK_SEL_W-1:0]  wr_bank, rd_bank_a, rd_bank_b;
  logic [BANK_ADDR_W-1:0] wr_off, rd_off_a, rd_off_b;
  logic [DATA_W-1:0]      rd_data_a, rd_data_b;
  logic                   rd_go_a, rd_go_b;

  assign wr_bank   = wr_addr[ADDR_W-1 -: BANK_SEL_W];
  assign wr_off    = wr_addr[BANK_ADDR_W-1:0];
  assign rd_bank_a = rd_addr_a[ADDR_W-1 -: BANK_SEL_W];
  assign rd_off_a  = rd_addr_a[BANK_ADDR_W-1:0];
  assign rd_bank_b = rd_addr_b[ADDR_W-1 -: BANK_SEL_W];
  assign rd_off_b  = rd_addr_b[BANK_ADDR_W-1:0];

  assign rd_go_a = (state == READY) && rd_en_a;
  assign rd_go_b = (state == READY) && rd_en_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= INIT;
      clr_ptr   <= '0;
      init_busy <= 1'b1;
    end else if (state == INIT) begin
      clr_ptr <= clr_ptr + 1'b1;
      if (clr_ptr == '1) begin
        state     <= READY;
        init_busy <= 1'b0;
      end
    end
  end

  // Sweep clears the same offset in every bank each cycle, so DEPTH cycles cover the whole array.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      for (int unsigned b = 0; b < NBANK; b++)
        mem[BANK_SEL_W'(b)][clr_ptr] <= '0;
    end else if (wr) begin
      mem[wr_bank][wr_off] <= d_in;
    end
  end

  always_comb begin
    rd_data_a = mem[rd_bank_a][rd_off_a];
    rd_data_b = mem[rd_bank_b][rd_off_b];
`ifdef BANKED_RAM_BYPASS_EN
    if (wr && (wr_addr == rd_addr_a)) rd_data_a = d_in;
    if (wr && (wr_addr == rd_addr_b)) rd_data_b = d_in;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_out_a <= '0;
      d_out_b <= '0;
      valid_a <= 1'b0;
      valid_b <= 1'b0;
    end else begin
      valid_a <= rd_go_a;
      valid_b <= rd_go_b;
      if (rd_go_a) d_out_a <= rd_data_a;
      if (rd_go_b) d_out_b <= rd_data_b;
    end
  end

endmodule

// File: tb/tb_banked_ram_2r1w.sv
// Directed bench for banked_ram_2r1w: clear sweep, banking, collisions, valid strobes, reset behaviour.
module tb_banked_ram_2r1w;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr;
  logic [12:0] wr_addr;
  logic [15:0] d_in;
  logic        rd_en_a;
  logic [12:0] rd_addr_a;
  logic        rd_en_b;
  logic [12:0] rd_addr_b;
  logic [15:0] d_out_a, d_out_b;
  logic        valid_a, valid_b, init_busy;

  int errors = 0;
  int checks = 0;

  banked_ram_2r1w #(.DATA_W(16), .BANK_SEL_W(3), .BANK_ADDR_W(10)) dut (
    .clk(clk), .reset(reset), .wr(wr), .wr_addr(wr_addr), .d_in(d_in),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b),
    .d_out_a(d_out_a), .valid_a(valid_a), .d_out_b(d_out_b), .valid_b(valid_b),
    .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr = 1'b0; wr_addr = '0; d_in = '0;
    rd_en_a = 1'b0; rd_addr_a = '0;
    rd_en_b = 1'b0; rd_addr_b = '0;
  endtask

  // Counts edges after reset release; init_busy must fall on exactly the 1024th.
  task automatic test_sweep(input bit junk);
    if (junk) begin
      wr = 1'b1; wr_addr = 13'h0003; d_in = 16'hFFFF;
      rd_en_a = 1'b1; rd_addr_a = 13'h0003;
    end
    for (int i = 1; i <= 1024; i++) begin
      tick();
      checks++;
      if (init_busy !== (i < 1024)) begin
        errors++;
        $display("FAIL sweep_busy edge=%0d got=%b exp=%b", i, init_busy, (i < 1024));
      end
      checks++;
      if (valid_a !== 1'b0 || d_out_a !== 16'h0000) begin
        errors++;
        $display("FAIL sweep_quiet edge=%0d valid_a=%b d_out_a=%h exp 0/0000", i, valid_a, d_out_a);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #3;
    checks++;
    if (d_out_a !== 16'h0 || d_out_b !== 16'h0 || valid_a !== 1'b0 || valid_b !== 1'b0 || init_busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_state got a=%h b=%h va=%b vb=%b busy=%b exp 0 0 0 0 1",
               d_out_a, d_out_b, valid_a, valid_b, init_busy);
    end
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_cleared_reads();
    logic [12:0] addrs [3];
    addrs[0] = 13'h1FFF; addrs[1] = 13'h0000; addrs[2] = 13'h0003;
    for (int i = 0; i < 3; i++) begin
      rd_en_a = 1'b1; rd_addr_a = addrs[i];
      tick();
      checks++;
      if (d_out_a !== 16'h0000 || valid_a !== 1'b1) begin
        errors++;
        $display("FAIL clear_read addr=%h got=%h/%b exp=0000/1", addrs[i], d_out_a, valid_a);
      end
    end
    idle_inputs();
  endtask

  task automatic test_banks();
    logic [12:0] wa [3];
    logic [15:0] wd [3];
    wa[0] = 13'h0005; wd[0] = 16'hBEEF;
    wa[1] = 13'h0405; wd[1] = 16'h1234;
    wa[2] = 13'h1C05; wd[2] = 16'hCAFE;
    for (int i = 0; i < 3; i++) begin
      wr = 1'b1; wr_addr = wa[i]; d_in = wd[i];
      tick();
    end
    wr = 1'b0;
    rd_en_a = 1'b1; rd_addr_a = 13'h0405;
    rd_en_b = 1'b1; rd_addr_b = 13'h1C05;
    tick();
    checks++;
    if (d_out_a !== 16'h1234 || valid_a !== 1'b1) begin
      errors++;
      $display("FAIL bank1_read got=%h/%b exp=1234/1", d_out_a, valid_a);
    end
    checks++;
    if (d_out_b !== 16'hCAFE || valid_b !== 1'b1) begin
      errors++;
      $display("FAIL bank7_read got=%h/%b exp=cafe/1", d_out_b, valid_b);
    end
    rd_addr_a = 13'h0005; rd_addr_b = 13'h0005;
    tick();
    checks++;
    if (d_out_a !== 16'hBEEF || d_out_b !== 16'hBEEF) begin
      errors++;
      $display("FAIL same_addr_read got a=%h b=%h exp=beef beef", d_out_a, d_out_b);
    end
    idle_inputs();
  endtask

  task automatic test_collision();
    logic [15:0] exp_coll;
`ifdef BANKED_RAM_BYPASS_EN
    exp_coll = 16'h2222;
`else
    exp_coll = 16'h1111;
`endif
    wr = 1'b1; wr_addr = 13'h0777; d_in = 16'h1111;
    tick();
    d_in = 16'h2222;
    rd_en_a = 1'b1; rd_addr_a = 13'h0777;
    rd_en_b = 1'b1; rd_addr_b = 13'h0405;
    tick();
    checks++;
    if (d_out_a !== exp_coll) begin
      errors++;
      $display("FAIL collision_read got=%h exp=%h", d_out_a, exp_coll);
    end
    checks++;
    if (d_out_b !== 16'h1234) begin
      errors++;
      $display("FAIL diff_addr_read got=%h exp=1234", d_out_b);
    end
    wr = 1'b0; rd_en_b = 1'b0;
    tick();
    checks++;
    if (d_out_a !== 16'h2222) begin
      errors++;
      $display("FAIL collision_after got=%h exp=2222", d_out_a);
    end
    idle_inputs();
  endtask

  task automatic test_valid_pulse();
    rd_en_b = 1'b1; rd_addr_b = 13'h0405;
    tick();
    checks++;
    if (valid_b !== 1'b1 || d_out_b !== 16'h1234) begin
      errors++;
      $display("FAIL pulse_read got=%h/%b exp=1234/1", d_out_b, valid_b);
    end
    rd_en_b = 1'b0; rd_addr_b = 13'h0005;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (valid_b !== 1'b0 || d_out_b !== 16'h1234) begin
        errors++;
        $display("FAIL pulse_hold cyc=%0d got=%h/%b exp=1234/0", i, d_out_b, valid_b);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_read();
    wr = 1'b1; wr_addr = 13'h0100; d_in = 16'hAAAA;
    tick();
    wr = 1'b0;
    rd_en_a = 1'b1; rd_addr_a = 13'h0100;
    tick();
    checks++;
    if (d_out_a !== 16'hAAAA || valid_a !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_read got=%h/%b exp=aaaa/1", d_out_a, valid_a);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (d_out_a !== 16'h0000 || valid_a !== 1'b0 || init_busy !== 1'b1) begin
      errors++;
      $display("FAIL async_reset got=%h/%b busy=%b exp=0000/0 busy=1", d_out_a, valid_a, init_busy);
    end
    idle_inputs();
    tick(); tick();
    reset = 1'b0;
    test_sweep(1'b0);
    rd_en_a = 1'b1; rd_addr_a = 13'h0100;
    tick();
    checks++;
    if (d_out_a !== 16'h0000 || valid_a !== 1'b1) begin
      errors++;
      $display("FAIL resweep_read got=%h/%b exp=0000/1", d_out_a, valid_a);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_sweep(1'b1);
    test_cleared_reads();
    test_banks();
    test_collision();
    test_valid_pulse();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
